// File: rtl/poc_pkg.sv
// Parallel output controller shared definitions.
// Register map, mode/ready constants and transfer FSM encoding.
package poc_pkg;

    localparam logic [2:0] ADDR_SR0 = 3'b000;
    localparam logic [2:0] ADDR_SR1 = 3'b001;
    localparam logic [2:0] ADDR_BR  = 3'b100;
    localparam logic [2:0] ADDR_SR7 = 3'b111;

    localparam logic POLLING   = 1'b0;
    localparam logic INTERRUPT = 1'b1;
    localparam logic READY     = 1'b1;
    localparam logic BUSY      = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_STROBE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

endpackage

// File: rtl/poc_print_fsm.sv
// Printer transfer engine: handshake FSM, strobe and ack-timeout counters.
// Ports: start (SR7 busy), br, rdy in; tr, pd registered; done, err pulses.
module poc_print_fsm
    import poc_pkg::*;
#(
    parameter int TR_CYCLES   = 4,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] br,
    input  logic       rdy,
    output logic       tr,
    output logic [7:0] pd,
    output logic       done,
    output logic       err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int SW = (TR_CYCLES > 1) ? $clog2(TR_CYCLES) : 1;

    localparam logic [SW-1:0] S_LAST  = SW'(TR_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_SAT  = TW'(ACK_TIMEOUT);

    state_t        state;
    logic [SW-1:0] scnt;
    logic [TW-1:0] tcnt;

    // done/err are combinational so the top can set SR7 on the very
    // edge the FSM returns to IDLE; a registered pulse would let IDLE
    // see a stale SR7 = 0 and start a spurious second transfer.
    assign done = (state == S_WAIT_DONE) && (rdy == READY);
    assign err  = (state == S_WAIT_ACK) && (rdy == READY)
                  && (tcnt >= TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            tr    <= 1'b0;
            pd    <= 8'h00;
            scnt  <= '0;
            tcnt  <= '0;
        end else begin
            // Timeout count is measured from tr rise; saturates.
            if (tcnt != TO_SAT)
                tcnt <= tcnt + 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (start)
                        state <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (rdy == READY) begin
                        state <= S_STROBE;
                        pd    <= br;
                        tr    <= 1'b1;
                        scnt  <= '0;
                        tcnt  <= '0;
                    end
                end
                S_STROBE: begin
                    if (scnt == S_LAST) begin
                        tr    <= 1'b0;
                        state <= S_WAIT_ACK;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (rdy == BUSY)
                        state <= S_WAIT_DONE;
                    else if (err)
                        state <= S_IDLE;
                end
                S_WAIT_DONE: begin
                    if (rdy == READY)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/poc.sv
// Parallel output controller: processor register file plus printer port.
// Ports: clk, rst_n, addr/rw/reg_in/data_in bus, reg_out, irq; rdy, tr, pd.
module poc
    import poc_pkg::*;
#(
    parameter int TR_CYCLES   = 4,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] addr,
    input  logic       rw,
    input  logic       reg_in,
    input  logic [7:0] data_in,
    output logic       reg_out,
    output logic       irq,
    input  logic       rdy,
    output logic       tr,
    output logic [7:0] pd
);

    logic       sr0;
    logic       sr1;
    logic       sr7;
    logic [7:0] br;
    logic [7:0] sr;
    logic       done;
    logic       err;

    logic wr_sr0;
    logic wr_sr1;
    logic wr_sr7;
    logic wr_br;

    assign wr_sr0 = rw && (addr == ADDR_SR0);
    assign wr_sr1 = rw && (addr == ADDR_SR1);
    assign wr_sr7 = rw && (addr == ADDR_SR7);
    assign wr_br  = rw && (addr == ADDR_BR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr0 <= POLLING;
            sr1 <= 1'b0;
            sr7 <= READY;
            br  <= 8'h00;
        end else begin
            if (wr_sr0)
                sr0 <= reg_in;
            // A fresh error outranks a simultaneous clear so it is not lost.
            if (err)
                sr1 <= 1'b1;
            else if (wr_sr1)
                sr1 <= 1'b0;
            // Processor write to SR7 outranks the FSM completion set.
            if (wr_sr7)
                sr7 <= reg_in;
            else if (done || err)
                sr7 <= READY;
            if (wr_br)
                br <= data_in;
        end
    end

    assign sr      = {sr7, 5'b00000, sr1, sr0};
    assign reg_out = rw ? 1'b0 : sr[addr];
    assign irq     = ~(sr0 & sr7);

    poc_print_fsm #(
        .TR_CYCLES  (TR_CYCLES),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_fsm (
        .clk  (clk),
        .rst_n(rst_n),
        .start(sr7 == BUSY),
        .br   (br),
        .rdy  (rdy),
        .tr   (tr),
        .pd   (pd),
        .done (done),
        .err  (err)
    );

endmodule

// File: doc/poc.md
POC -- requirements
Module: poc

Interface
REQ-001 Parameter TR_CYCLES, default 4: number of clk cycles tr is held high per character.
REQ-002 Parameter ACK_TIMEOUT, default 1000: max cycles from tr rise to printer rdy fall before an error is flagged.
REQ-003 clk  in  1  system clock, 50 MHz; all state is updated on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 addr  in  3  register address: 000 = SR0 (mode), 001 = SR1 (error), 100 = BR (data buffer), 111 = SR7 (ready/busy).
REQ-006 rw  in  1  1 = write, 0 = read.
REQ-007 reg_in  in  1  bit value written to SR[addr].
REQ-008 data_in  in  8  byte written to BR.
REQ-009 reg_out  out  1  SR[addr] when rw=0; 0 when rw=1.
REQ-010 irq  out  1  interrupt to processor, active-low.
REQ-011 rdy  in  1  printer ready, 1 = idle or able to accept.
REQ-012 tr  out  1  transfer request strobe to printer.
REQ-013 pd  out  8  parallel data to printer.

Function
REQ-014 SR is an 8-bit register; only SR0, SR1 and SR7 are implemented, and all other bits read 0.
REQ-015 Write with rw=1 and addr=000 or 111 loads reg_in into SR0 or SR7 at the next edge.
REQ-016 Write with rw=1 and addr=100 loads data_in into BR at the next edge.
REQ-017 Write with rw=1 and addr=001 clears SR1, regardless of reg_in.
REQ-018 Writes to any other address are ignored.
REQ-019 reg_out is combinational from SR and addr, with zero latency.
REQ-020 irq = ~(SR0 & SR7), combinational.
REQ-021 irq is therefore low only in interrupt mode with POC ready, and it goes high in the cycle after the processor clears SR7.
REQ-022 The transfer FSM has five states: IDLE, WAIT_RDY, STROBE, WAIT_ACK, WAIT_DONE.
REQ-023 IDLE -> WAIT_RDY when SR7 = 0.
REQ-024 WAIT_RDY -> STROBE when rdy = 1; on entering STROBE, pd is loaded from BR.
REQ-025 STROBE holds tr = 1 for exactly TR_CYCLES cycles, then -> WAIT_ACK with tr = 0.
REQ-026 WAIT_ACK -> WAIT_DONE on rdy = 0.
REQ-027 If rdy is not seen low within ACK_TIMEOUT cycles of tr rise, set SR1 = 1, set SR7 = 1 and go -> IDLE.
REQ-028 WAIT_DONE -> IDLE on rdy = 1, setting SR7 = 1 on that same edge.
REQ-029 pd holds its value until the next STROBE entry; a BR write during a transfer does not alter pd.
REQ-030 If a processor write to SR7 and an FSM set of SR7 occur on the same edge, the processor write wins.
REQ-031 A processor write of SR7 = 1 while busy does not abort the FSM; the current character completes.
REQ-032 The timeout counter width is ceil(log2(ACK_TIMEOUT+1)) bits and saturates; it does not wrap.
REQ-033 A mode change (SR0 write) mid-transfer affects only irq, not the FSM.
REQ-034 Latency from SR7 cleared to tr rise is 2 cycles when rdy = 1.

Reset
REQ-035 On rst_n low, asynchronously: SR = 8'h80 (SR7 = 1, SR0 = 0, SR1 = 0), BR = 0, pd = 0, tr = 0, FSM = IDLE, counters = 0.
REQ-036 Outputs during reset are therefore irq = 1 and reg_out = SR[addr].
REQ-037 Reset mid-transfer drops tr within the reset assertion and loses the character.
REQ-038 Reset release is synchronised to clk by the existing reset scheme.

Structure
REQ-039 Package poc_pkg holds: register addresses, mode constants POLLING = 0 and INTERRUPT = 1, READY = 1 and BUSY = 0, and the FSM state encoding.
REQ-040 One sub-module, poc_print_fsm, contains the transfer FSM, the strobe counter and the timeout counter; it has ports start, br, rdy, tr, pd, done, err.
REQ-041 poc top contains the register file, the read mux, irq generation and SR7/SR1 priority logic.

Verification
REQ-042 Polling: write SR0 = 0, write BR = 8'h48, write SR7 = 0, rdy = 1, printer model drops rdy 3 cycles after tr and raises it 10 cycles later -> pd = 8'h48, tr high 4 cycles, SR7 reads 1 after rdy rise, irq stays 1.
REQ-043 Interrupt: write SR0 = 1 -> irq = 0; write BR = 8'h20, write SR7 = 0 -> irq = 1 the next cycle and returns to 0 after printer completion.
REQ-044 Timeout: rdy held 1 after tr, ACK_TIMEOUT = 16 -> SR1 = 1 and SR7 = 1 on cycle 16 after tr rise; a write to addr 001 then clears SR1.
REQ-045 BR overwrite: write BR = 8'h55 during WAIT_ACK -> pd stays at the old byte; the next transfer sends 8'h55.
REQ-046 Reset mid-STROBE: assert rst_n low -> tr = 0, SR = 8'h80 and pd = 0 immediately.
REQ-047 Full message: the processor sends a 24-character polling message followed by a 26-character interrupt message -> the printer model captures both byte sequences in order, with no drops or duplicates.
